// File: rtl/uart_rx_frontend.sv
// UART receiver front end: 2-flop synchronizer, oversampling tick generator, frame FSM.
// Define UART_RX_PARITY_EN to add an even-parity bit between the data and stop bits.
module uart_rx_frontend #(
  parameter int unsigned N_BITS   = 8,
  parameter int unsigned N_TICKS  = 16,
  parameter int unsigned BAUD_DIV = 163
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_rx,
  output logic [N_BITS-1:0] o_rx_data,
  output logic              o_rx_done,
  output logic              o_framing_error,
  output logic              o_parity_error
);

  localparam int unsigned DW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int unsigned TW = (N_TICKS > 1) ? $clog2(N_TICKS) : 1;
  localparam int unsigned BW = (N_BITS > 1) ? $clog2(N_BITS) : 1;

  localparam logic [DW-1:0] BAUD_LAST = DW'(BAUD_DIV - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(N_TICKS - 1);
  localparam logic [TW-1:0] TICK_MID  = TW'(N_TICKS / 2 - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(N_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  // Synchronizer and edge-detect history
  logic rx_meta_q, rx_s_q, rx_prev_q;

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= i_rx;
      rx_s_q    <= rx_meta_q;
      rx_prev_q <= rx_s_q;
    end
  end

  // Free-running oversample tick
  logic [DW-1:0] baud_q, baud_d;
  logic          tick;

  always_comb begin
    tick   = (baud_q == BAUD_LAST);
    baud_d = tick ? '0 : baud_q + 1'b1;
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset) baud_q <= '0;
    else          baud_q <= baud_d;
  end

  state_t            state_q, state_d;
  logic [TW-1:0]     tick_cnt_q, tick_cnt_d;
  logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [N_BITS-1:0] shift_q, shift_d;
  logic [N_BITS-1:0] data_q, data_d;
  logic              done_q, done_d;
  logic              ferr_q, ferr_d;
`ifdef UART_RX_PARITY_EN
  logic              par_q, par_d;
  logic              perr_q, perr_d;
`endif

  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    data_d     = data_q;
    done_d     = 1'b0;
    ferr_d     = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d      = par_q;
    perr_d     = 1'b0;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (rx_prev_q && !rx_s_q) begin
          state_d    = S_START;
          tick_cnt_d = '0;
        end
      end
      S_START: begin
        if (tick) begin
          if (tick_cnt_q == TICK_MID) begin
            tick_cnt_d = '0;
            bit_cnt_d  = '0;
            state_d    = rx_s_q ? S_IDLE : S_DATA;
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
      end
      S_DATA: begin
        if (tick) begin
          if (tick_cnt_q == TICK_LAST) begin
            tick_cnt_d = '0;
            shift_d    = {rx_s_q, shift_q[N_BITS-1:1]};
            if (bit_cnt_q == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
              state_d = S_PARITY;
`else
              state_d = S_STOP;
`endif
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (tick) begin
          if (tick_cnt_q == TICK_LAST) begin
            tick_cnt_d = '0;
            par_d      = rx_s_q;
            state_d    = S_STOP;
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
      end
`endif
      S_STOP: begin
        if (tick) begin
          if (tick_cnt_q == TICK_LAST) begin
            tick_cnt_d = '0;
            state_d    = S_IDLE;
            // A bad stop bit suppresses delivery and any parity report
            if (rx_s_q) begin
              data_d = shift_q;
              done_d = 1'b1;
`ifdef UART_RX_PARITY_EN
              perr_d = (par_q != ^shift_q);
`endif
            end else begin
              ferr_d = 1'b1;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      state_q    <= S_IDLE;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      data_q     <= '0;
      done_q     <= 1'b0;
      ferr_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q      <= 1'b0;
      perr_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      done_q     <= done_d;
      ferr_q     <= ferr_d;
`ifdef UART_RX_PARITY_EN
      par_q      <= par_d;
      perr_q     <= perr_d;
`endif
    end
  end

  assign o_rx_data       = data_q;
  assign o_rx_done       = done_q;
  assign o_framing_error = ferr_q;
`ifdef UART_RX_PARITY_EN
  assign o_parity_error  = perr_q;
`else
  assign o_parity_error  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_frontend.sv
// Directed bench for uart_rx_frontend at BAUD_DIV=4, N_TICKS=16 (64 clocks per bit).
// Define UART_RX_PARITY_EN for both files to exercise the parity bit.
module tb_uart_rx_frontend;

  localparam int unsigned BIT_CLKS = 64;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_done, ferr, perr;

  int checks = 0;
  int errors = 0;

  int         done_cyc = 0;
  int         ferr_cyc = 0;
  int         perr_cyc = 0;
  int         done_ferr_cyc = 0;
  int         done_perr_cyc = 0;
  logic [7:0] got_q[$];

  uart_rx_frontend #(
    .N_BITS  (8),
    .N_TICKS (16),
    .BAUD_DIV(4)
  ) dut (
    .i_clock        (clk),
    .i_reset        (rst_n),
    .i_rx           (rx),
    .o_rx_data      (rx_data),
    .o_rx_done      (rx_done),
    .o_framing_error(ferr),
    .o_parity_error (perr)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rx_done) begin
      done_cyc++;
      got_q.push_back(rx_data);
    end
    if (ferr)            ferr_cyc++;
    if (perr)            perr_cyc++;
    if (rx_done && ferr) done_ferr_cyc++;
    if (rx_done && perr) done_perr_cyc++;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic hold(input logic v, input int unsigned n);
    rx = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par_b, input logic stop_b);
    hold(1'b0, BIT_CLKS);
    for (int i = 0; i < 8; i++) hold(d[i], BIT_CLKS);
`ifdef UART_RX_PARITY_EN
    hold(par_b, BIT_CLKS);
`else
    if (par_b) begin end
`endif
    hold(stop_b, BIT_CLKS);
    rx = 1'b1;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int d0, f0, p0;
    logic [7:0] frame3c;

    rx    = 1'b1;
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    check_eq("rst_data", rx_data, 8'h00);
    check_eq("rst_done", rx_done, 1'b0);
    check_eq("rst_ferr", ferr, 1'b0);
    check_eq("rst_perr", perr, 1'b0);
    rst_n = 1'b1;
    hold(1'b1, 20);

    // Single good frame
    d0 = done_cyc; f0 = ferr_cyc; p0 = perr_cyc;
    send_frame(8'h55, 1'b0, 1'b1);
    hold(1'b1, 40);
    check_eq("f55_done", done_cyc - d0, 1);
    check_eq("f55_data", rx_data, 8'h55);
    check_eq("f55_ferr", ferr_cyc - f0, 0);
    check_eq("f55_perr", perr_cyc - p0, 0);

    // Back-to-back 0xFF frames
    got_q.delete();
    d0 = done_cyc; f0 = ferr_cyc;
    for (int k = 0; k < 4; k++) send_frame(8'hFF, 1'b0, 1'b1);
    hold(1'b1, 40);
    check_eq("ff_done", done_cyc - d0, 4);
    check_eq("ff_ferr", ferr_cyc - f0, 0);
    check_eq("ff_qlen", got_q.size(), 4);
    for (int k = 0; k < 4 && got_q.size() > 0; k++) check_eq("ff_data", got_q.pop_front(), 8'hFF);

    // Short low glitch
    d0 = done_cyc; f0 = ferr_cyc;
    hold(1'b0, 12);
    hold(1'b1, 200);
    check_eq("gl_done", done_cyc - d0, 0);
    check_eq("gl_ferr", ferr_cyc - f0, 0);
    check_eq("gl_data", rx_data, 8'hFF);

    // Framing error
    d0 = done_cyc; f0 = ferr_cyc; p0 = perr_cyc;
    send_frame(8'hA3, 1'b0, 1'b0);
    hold(1'b1, 200);
    check_eq("fe_ferr", ferr_cyc - f0, 1);
    check_eq("fe_done", done_cyc - d0, 0);
    check_eq("fe_data", rx_data, 8'hFF);
    check_eq("fe_perr", perr_cyc - p0, 0);

    // Reset mid bit 4 of 0x3C, then a full 0x12
    frame3c = 8'h3C;
    hold(1'b0, BIT_CLKS);
    for (int i = 0; i < 4; i++) hold(frame3c[i], BIT_CLKS);
    hold(frame3c[4], BIT_CLKS / 2);
    rst_n = 1'b0;
    repeat (4) @(negedge clk);
    check_eq("mr_data", rx_data, 8'h00);
    rx    = 1'b1;
    rst_n = 1'b1;
    hold(1'b1, 100);
    got_q.delete();
    d0 = done_cyc; f0 = ferr_cyc;
    send_frame(8'h12, 1'b0, 1'b1);
    hold(1'b1, 200);
    check_eq("mr_done", done_cyc - d0, 1);
    check_eq("mr_ferr", ferr_cyc - f0, 0);
    check_eq("mr_data12", rx_data, 8'h12);
    check_eq("mr_qlen", got_q.size(), 1);

`ifdef UART_RX_PARITY_EN
    // 0x07 has odd weight; even parity bit should be 1, send 0
    d0 = done_cyc; p0 = perr_cyc;
    send_frame(8'h07, 1'b0, 1'b1);
    hold(1'b1, 40);
    check_eq("par_done", done_cyc - d0, 1);
    check_eq("par_perr", perr_cyc - p0, 1);
    check_eq("par_same", done_perr_cyc, 1);
    check_eq("par_data", rx_data, 8'h07);
`else
    check_eq("perr_tied", perr_cyc, 0);
`endif

    check_eq("done_ferr_excl", done_ferr_cyc, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_frontend.md
UART_RX_FRONTEND -- requirements
Module: uart_rx_frontend

Interface
REQ-001 Parameter N_BITS, default 8, data bits per frame.
REQ-002 Parameter N_TICKS, default 16, oversample ticks per bit.
REQ-003 Parameter BAUD_DIV, default 163, clock cycles per oversample tick (50 MHz, 19200 baud).
REQ-004 i_clock  input  1  single clock; all logic on posedge.
REQ-005 i_reset  input  1  synchronous reset, active-low (asserted when 0).
REQ-006 i_rx  input  1  asynchronous serial line, idle high.
REQ-007 o_rx_data  output  N_BITS  last received byte, LSB first on the line.
REQ-008 o_rx_done  output  1  one-cycle pulse marking o_rx_data valid; feeds the debug unit's byte-done input.
REQ-009 o_framing_error  output  1  one-cycle pulse, stop bit sampled low.
REQ-010 o_parity_error  output  1  one-cycle pulse, parity mismatch.

Function
REQ-011 i_rx SHALL pass through a 2-flop synchronizer; all decisions use the synchronized value rx_s.
REQ-012 Tick generator SHALL free-run 0..BAUD_DIV-1, tick high for one cycle when count equals BAUD_DIV-1, then wrap to 0.
REQ-013 FSM states SHALL be IDLE, START, DATA, PARITY (macro only), STOP.
REQ-014 IDLE: falling edge of rx_s (previous 1, current 0) SHALL enter START and clear the tick counter; a line held low SHALL NOT retrigger.
REQ-015 START: on the tick where the tick counter reaches N_TICKS/2-1 (mid start bit), rx_s low SHALL enter DATA with the tick and bit counters cleared; rx_s high SHALL return to IDLE as a glitch, with no output pulse.
REQ-016 DATA: every N_TICKS ticks SHALL shift rx_s into the MSB of the shift register (right-shift, LSB first); after N_BITS samples SHALL enter STOP, or PARITY when the macro is defined.
REQ-017 STOP: after N_TICKS ticks SHALL sample rx_s and return to IDLE.
REQ-018 Stop sample high: o_rx_data SHALL load the shift register and o_rx_done SHALL pulse in the following cycle.
REQ-019 Stop sample low: o_framing_error SHALL pulse, o_rx_done SHALL stay low, and o_rx_data SHALL be unchanged.
REQ-020 o_rx_data SHALL hold its value until the next successful frame.
REQ-021 Back-to-back frames with no idle gap beyond one stop bit SHALL all be received.
REQ-022 o_rx_done and o_framing_error SHALL never be high in the same cycle.

Reset
REQ-023 While i_reset=0: FSM to IDLE, all counters to 0, synchronizer flops and previous-sample register to 1, shift register and o_rx_data to 0, all pulse outputs to 0.
REQ-024 Reset mid-frame SHALL abort the frame without a pulse; reception restarts on the next falling edge after release.

Configuration
REQ-025 Macro UART_RX_PARITY_EN SHALL control the even-parity feature.
REQ-026 Defined: the PARITY state samples one bit N_TICKS ticks after the last data bit, then goes to STOP.
REQ-027 Defined: a parity mismatch SHALL pulse o_parity_error in the same cycle as o_rx_done. Data is still delivered.
REQ-028 Defined: a framing error SHALL take priority, with no o_parity_error pulse for that frame.
REQ-029 Not defined: there is no PARITY state, the frame is 10 bits, and o_parity_error is tied 0.

Verification (BAUD_DIV=4, N_TICKS=16, bit = 64 clocks)
REQ-030 Frame 0x55 with good stop -> o_rx_done one cycle, o_rx_data=0x55, no error pulses.
REQ-031 Four back-to-back 0xFF frames -> four o_rx_done pulses, o_rx_data=0xFF each.
REQ-032 i_rx low for 12 clocks then high -> FSM returns to IDLE, no output pulse.
REQ-033 Frame 0xA3 with stop bit low -> o_framing_error one cycle, no o_rx_done, o_rx_data keeps its previous value.
REQ-034 Reset asserted mid-bit 4 of 0x3C, then full frame 0x12 -> only 0x12 reported, exactly one o_rx_done.
REQ-035 With UART_RX_PARITY_EN, 0x07 sent with parity bit 0 -> o_rx_done and o_parity_error in the same cycle, o_rx_data=0x07.
